// File: rtl/equal_segmentation_arbiter32.sv
// equal_segmentation_arbiter32
//   Two requesters share one approximate segmented 32-bit adder. Each
//   segment adds with carry-in 0, and the inter-segment carries are dropped
//   and reported. A round-robin grant is made in IDLE. Operands are
//   registered, summed in EXEC, and the result is held in DONE until the
//   consumer takes it.
//   Optional macro ESA_CARRY_CORRECT_EN adds a CORR state. CORR folds the
//   dropped carries back in, which gives the exact 33-bit sum.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   reqN_valid_i / reqN_ready_o     requester N handshake (N = 0,1)
//   reqN_add1_i, reqN_add2_i        requester N operands (32b)
//   result_o (33b), result_id_o     sum and owning requester
//   seg_carry_o (3b)                dropped carry-outs of segments 0..2
//   result_valid_o / result_ready_i result handshake

// One segment: plain add, carry-in tied to 0.
module esa_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// Segmented adder: one esa_seg per SEG_W slice. The top segment's carry
// becomes sum[32]. The lower carries are exported, not propagated.
module equal_segmentation_adder32 #(
  parameter int SEG_W = 8
) (
  input  logic [31:0]           a,
  input  logic [31:0]           b,
  output logic [32:0]           sum,
  output logic [32/SEG_W-2:0]   seg_carry
);
  localparam int NSEG = 32 / SEG_W;
  logic [NSEG-1:0]            cout;
  logic [NSEG-1:0][SEG_W-1:0] a_seg, b_seg, s_seg;

  assign a_seg = a;
  assign b_seg = b;

  for (genvar i = 0; i < NSEG; i++) begin : g_seg
    esa_seg #(.W(SEG_W)) u_seg (
      .a(a_seg[i]), .b(b_seg[i]), .sum(s_seg[i]), .cout(cout[i])
    );
  end

  assign sum       = {cout[NSEG-1], s_seg};
  assign seg_carry = cout[NSEG-2:0];
endmodule

module equal_segmentation_arbiter32 #(
  parameter int SEG_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_add1_i,
  input  logic [31:0] req0_add2_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_add1_i,
  input  logic [31:0] req1_add2_i,
  output logic [32:0] result_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic        result_id_o,
  output logic [2:0]  seg_carry_o
);
  typedef struct packed {
    logic [31:0] add1;
    logic [31:0] add2;
  } op_t;

`ifdef ESA_CARRY_CORRECT_EN
  typedef enum logic [1:0] {IDLE, EXEC, CORR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
`endif

  state_t      state;
  op_t         op_q;
  logic        id_q;
  logic        last_q;   // last granted requester; reset to 1 so req0 wins first
  logic        grant0, grant1, accept;
  logic [32:0] add_sum;
  logic [2:0]  add_c;

  // The requester that was not granted last has priority under contention.
  assign grant0 = req0_valid_i & (~req1_valid_i | last_q);
  assign grant1 = req1_valid_i & (~req0_valid_i | ~last_q);

  // Ready is gated by reset because state is only forced asynchronously.
  assign req0_ready_o = rst_ni & (state == IDLE) & grant0;
  assign req1_ready_o = rst_ni & (state == IDLE) & grant1;
  assign accept       = req0_ready_o | req1_ready_o;

  equal_segmentation_adder32 #(.SEG_W(SEG_W)) u_add (
    .a(op_q.add1), .b(op_q.add2), .sum(add_sum), .seg_carry(add_c)
  );

`ifdef ESA_CARRY_CORRECT_EN
  // Re-inject each dropped carry at the base of the next segment.
  logic [32:0] corr;
  always_comb begin
    corr = '0;
    for (int i = 0; i < 3; i++) corr[SEG_W*(i+1)] = seg_carry_o[i];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      op_q           <= '0;
      id_q           <= 1'b0;
      last_q         <= 1'b1;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= 1'b0;
      seg_carry_o    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q   <= req1_ready_o ? op_t'{req1_add1_i, req1_add2_i}
                                 : op_t'{req0_add1_i, req0_add2_i};
          id_q   <= req1_ready_o;
          last_q <= req1_ready_o;
          state  <= EXEC;
        end
        EXEC: begin
          result_o    <= add_sum;
          seg_carry_o <= add_c;
          result_id_o <= id_q;
`ifdef ESA_CARRY_CORRECT_EN
          if (|add_c) state <= CORR;
          else begin
            state          <= DONE;
            result_valid_o <= 1'b1;
          end
`else
          state          <= DONE;
          result_valid_o <= 1'b1;
`endif
        end
`ifdef ESA_CARRY_CORRECT_EN
        CORR: begin
          result_o       <= result_o + corr;
          state          <= DONE;
          result_valid_o <= 1'b1;
        end
`endif
        DONE: if (result_ready_i) begin
          result_valid_o <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
